// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and register-load helpers (bus mux, control unit, register file).
// Default width 32, sixteen general-purpose registers.
package cpu_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int IDX_W    = 4;

    typedef logic [IDX_W-1:0]    reg_idx_t;
    typedef logic [DATA_W-1:0]   word_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    function automatic logic is_multi_hot(input reg_mask_t mask);
        return (mask & (mask - reg_mask_t'(1))) != reg_mask_t'(0);
    endfunction

    function automatic logic is_one_hot(input reg_mask_t mask);
        return (mask != reg_mask_t'(0)) && !is_multi_hot(mask);
    endfunction

    // OR-encoder: exact for one-hot masks, which is the only case it is used for.
    function automatic reg_idx_t one_hot_to_idx(input reg_mask_t mask);
        reg_idx_t idx;
        idx = reg_idx_t'(0);
        for (int i = 0; i < NUM_REGS; i++) begin
            idx = idx | (mask[i] ? reg_idx_t'(i) : reg_idx_t'(0));
        end
        return idx;
    endfunction

endpackage

// File: rtl/reg_file_16x32_reg32.sv
// Single DATA_W-bit storage register with load enable and asynchronous active-low clear.
module reg32
    import cpu_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Storage flop: cleared asynchronously, loaded only when enabled.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            q_r <= {W{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/reg_file_16x32.sv
// Register bank R0..R15 with BAout gating of R0 and load-integrity flags.
// Optional debug tap (DbgSel/DbgData/LoadCount) enabled by defining REGFILE_DBG_EN.
module reg_file_16x32
    import cpu_pkg::*;
(
    input  logic      clock,
    input  logic      clear,
    input  word_t     BusMuxOut,
    input  reg_mask_t Rin,
    input  logic      BAout,
`ifdef REGFILE_DBG_EN
    input  reg_idx_t  DbgSel,
    output word_t     DbgData,
    output logic [15:0] LoadCount,
`endif
    output word_t     BusMuxInR0,
    output word_t     BusMuxInR1,
    output word_t     BusMuxInR2,
    output word_t     BusMuxInR3,
    output word_t     BusMuxInR4,
    output word_t     BusMuxInR5,
    output word_t     BusMuxInR6,
    output word_t     BusMuxInR7,
    output word_t     BusMuxInR8,
    output word_t     BusMuxInR9,
    output word_t     BusMuxInR10,
    output word_t     BusMuxInR11,
    output word_t     BusMuxInR12,
    output word_t     BusMuxInR13,
    output word_t     BusMuxInR14,
    output word_t     BusMuxInR15,
    output logic      WrValid,
    output reg_idx_t  WrIdx,
    output logic      MultiLoadErr
);

    word_t     regs_s [NUM_REGS];
    reg_mask_t load_en_s;
    reg_idx_t  load_idx_s;
    logic      load_ok_s;
    logic      load_multi_s;

    logic      wr_valid_r;
    reg_idx_t  wr_idx_r;
    logic      multi_err_r;

    // Decode the load strobes: a multi-hot Rin must not write any register.
    always_comb begin
        load_multi_s = is_multi_hot(Rin);
        load_ok_s    = is_one_hot(Rin);
        load_idx_s   = one_hot_to_idx(Rin);
        if (load_ok_s) begin
            load_en_s = Rin;
        end else begin
            load_en_s = reg_mask_t'(0);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg
            reg32 #(.W(DATA_W)) u_reg (
                .clock (clock),
                .clear (clear),
                .en    (load_en_s[g]),
                .d     (BusMuxOut),
                .q     (regs_s[g])
            );
        end
    endgenerate

    // Load status: pulse on a valid load, remember its index, latch any multi-hot strobe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_valid_r  <= 1'b0;
            wr_idx_r    <= reg_idx_t'(0);
            multi_err_r <= 1'b0;
        end else begin
            wr_valid_r <= load_ok_s;
            if (load_ok_s) begin
                wr_idx_r <= load_idx_s;
            end else begin
                wr_idx_r <= wr_idx_r;
            end
            if (load_multi_s) begin
                multi_err_r <= 1'b1;
            end else begin
                multi_err_r <= multi_err_r;
            end
        end
    end

    assign WrValid      = wr_valid_r;
    assign WrIdx        = wr_idx_r;
    assign MultiLoadErr = multi_err_r;

    // Base-address mode only masks the read of R0; the stored value is untouched.
    assign BusMuxInR0  = BAout ? word_t'(0) : regs_s[0];
    assign BusMuxInR1  = regs_s[1];
    assign BusMuxInR2  = regs_s[2];
    assign BusMuxInR3  = regs_s[3];
    assign BusMuxInR4  = regs_s[4];
    assign BusMuxInR5  = regs_s[5];
    assign BusMuxInR6  = regs_s[6];
    assign BusMuxInR7  = regs_s[7];
    assign BusMuxInR8  = regs_s[8];
    assign BusMuxInR9  = regs_s[9];
    assign BusMuxInR10 = regs_s[10];
    assign BusMuxInR11 = regs_s[11];
    assign BusMuxInR12 = regs_s[12];
    assign BusMuxInR13 = regs_s[13];
    assign BusMuxInR14 = regs_s[14];
    assign BusMuxInR15 = regs_s[15];

`ifdef REGFILE_DBG_EN
    word_t       dbg_data_r;
    logic [15:0] load_count_r;

    // Debug tap: raw register snapshot (BAout ignored) and a wrapping valid-load counter.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            dbg_data_r   <= word_t'(0);
            load_count_r <= 16'h0000;
        end else begin
            dbg_data_r <= regs_s[DbgSel];
            if (load_ok_s) begin
                load_count_r <= load_count_r + 16'h0001;
            end else begin
                load_count_r <= load_count_r;
            end
        end
    end

    assign DbgData   = dbg_data_r;
    assign LoadCount = load_count_r;
`else
    // Production build: no debug tap.
`endif

endmodule
